ws_bit_decoder: RTL and testbench

- Parametrised WS2812-style single-wire bit decoder with the high-time and low-time counters, input synchroniser and reset detection built in.
- Takes the raw serial line and classifies each high pulse with a window comparator. It checks low-period legality and detects stuck lines.
- Outputs one-cycle bit strobes, error strobes with a cause code, a treset level and a per-frame bit count.
- Sits between the pad input and the pipeline shift register, replacing the external edge detector plus fixed-threshold decode stage.

---
 rtl/ws_bit_decoder.sv | 174 +++++++++++++++++
 tb/tb_ws_bit_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_bit_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ws_bit_decoder : WS2812-style single-wire bit decoder (sync, window decode,
//                  low-time legality, stuck-line and treset detection)
// Revision 1.0
// ============================================================================
module ws_bit_decoder #(
    parameter int CNT_W         = 12,
    parameter int SYNC_STAGES   = 2,
    parameter int T0H_MIN       = 10,
    parameter int T0H_MAX       = 27,
    parameter int T1H_MIN       = 30,
    parameter int T1H_MAX       = 50,
    parameter int TLOW_MIN      = 10,
    parameter int TRESET_CYCLES = 2500,
    parameter int BITCNT_W      = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_din,
    output logic                o_bit,
    output logic                o_bit_valid,
    output logic                o_err,
    output logic [1:0]          o_err_code,
    output logic                o_treset,
    output logic [BITCNT_W-1:0] o_bit_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_T0H_MIN  = CNT_W'(T0H_MIN);
    localparam logic [CNT_W-1:0] c_T0H_MAX  = CNT_W'(T0H_MAX);
    localparam logic [CNT_W-1:0] c_T1H_MIN  = CNT_W'(T1H_MIN);
    localparam logic [CNT_W-1:0] c_T1H_MAX  = CNT_W'(T1H_MAX);
    localparam logic [CNT_W-1:0] c_TLOW_MIN = CNT_W'(TLOW_MIN);
    localparam logic [CNT_W-1:0] c_TRESET   = CNT_W'(TRESET_CYCLES);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [BITCNT_W-1:0] c_BITCNT_MAX = {BITCNT_W{1'b1}};

    localparam logic [1:0] c_ERR_HIGH_WIDTH = 2'd0;
    localparam logic [1:0] c_ERR_STUCK_HIGH = 2'd1;
    localparam logic [1:0] c_ERR_LOW_SHORT  = 2'd2;

    generate
        if (!(SYNC_STAGES >= 2 && T0H_MIN <= T0H_MAX && T0H_MAX < T1H_MIN &&
              T1H_MIN <= T1H_MAX && T1H_MAX < TRESET_CYCLES &&
              TLOW_MIN < TRESET_CYCLES && TRESET_CYCLES < (1 << CNT_W))) begin : g_bad_params
            $error("ws_bit_decoder: inconsistent timing parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_ARMED  = 2'd1,
        ST_HIGH   = 2'd2,
        ST_LOW    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_q;
    logic [CNT_W-1:0]       r_cnt;

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_s & ~r_s_q;
    assign w_fall    = ~w_s & r_s_q;
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_ONE;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_s_q  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_s_q  <= w_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_RESYNC;
            r_cnt       <= '0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= 2'd0;
            o_treset    <= 1'b0;
            o_bit_cnt   <= '0;
        end else begin
            o_bit_valid <= 1'b0;
            o_err       <= 1'b0;
            case (r_state)
                ST_RESYNC: begin
                    // Only an unbroken low run of TRESET_CYCLES re-arms the decoder.
                    if (w_s) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt >= c_TRESET) begin
                            r_state  <= ST_ARMED;
                            o_treset <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        r_cnt     <= c_ONE;
                        r_state   <= ST_HIGH;
                        o_treset  <= 1'b0;
                        o_bit_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        r_cnt <= c_ONE;
                        if (r_cnt >= c_T1H_MIN && r_cnt <= c_T1H_MAX) begin
                            o_bit       <= 1'b1;
                            o_bit_valid <= 1'b1;
                            o_bit_cnt   <= (o_bit_cnt == c_BITCNT_MAX) ? o_bit_cnt : o_bit_cnt + 1'b1;
                            r_state     <= ST_LOW;
                        end else if (r_cnt >= c_T0H_MIN && r_cnt <= c_T0H_MAX) begin
                            o_bit       <= 1'b0;
                            o_bit_valid <= 1'b1;
                            o_bit_cnt   <= (o_bit_cnt == c_BITCNT_MAX) ? o_bit_cnt : o_bit_cnt + 1'b1;
                            r_state     <= ST_LOW;
                        end else begin
                            o_err      <= 1'b1;
                            o_err_code <= c_ERR_HIGH_WIDTH;
                            r_state    <= ST_RESYNC;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt > c_T1H_MAX) begin
                            o_err      <= 1'b1;
                            o_err_code <= c_ERR_STUCK_HIGH;
                            r_state    <= ST_RESYNC;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_cnt <= c_ONE;
                        if (r_cnt < c_TLOW_MIN) begin
                            o_err      <= 1'b1;
                            o_err_code <= c_ERR_LOW_SHORT;
                            r_state    <= ST_RESYNC;
                        end else begin
                            r_state <= ST_HIGH;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt >= c_TRESET) begin
                            r_state  <= ST_ARMED;
                            o_treset <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RESYNC;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws_bit_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_ws_bit_decoder : scoreboard bench for ws_bit_decoder with a pulse-level
//                     reference model
// Revision 1.0
// ============================================================================
module tb_ws_bit_decoder;

    localparam int T0H_MIN  = 10;
    localparam int T0H_MAX  = 27;
    localparam int T1H_MIN  = 30;
    localparam int T1H_MAX  = 50;
    localparam int TLOW_MIN = 10;
    localparam int TRESET   = 2500;
    localparam int LONG_LO  = TRESET + 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        o_bit, o_bit_valid, o_err, o_treset;
    logic [1:0]  o_err_code;
    logic [15:0] o_bit_cnt;

    always #5 clk = ~clk;

    ws_bit_decoder dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_din       (din),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_treset    (o_treset),
        .o_bit_cnt   (o_bit_cnt)
    );

    typedef struct {
        bit       is_err;
        bit       b;
        bit [1:0] code;
        int       cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: decoder accepting pulses, waiting for first pulse of a frame, frame bit count.
    bit m_synced = 0;
    bit m_armed  = 0;
    int m_count  = 0;
    bit prev_v   = 0;
    bit prev_e   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (o_bit_valid || o_err)) begin
            check("strobe_exclusive", longint'(o_bit_valid & o_err), 0);
            check("strobe_single", longint'((o_bit_valid & prev_v) | (o_err & prev_e)), 0);
            if (q.size() == 0) begin
                check("unexpected_strobe_queue", q.size(), 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("strobe_kind_is_err", o_err, e.is_err);
                if (e.is_err) check("err_code", o_err_code, e.code);
                else          check("bit_value", o_bit, e.b);
                check("strobe_bit_cnt", o_bit_cnt, e.cnt);
            end
        end
        prev_v = rst_n & o_bit_valid;
        prev_e = rst_n & o_err;
    end

    task automatic push_err(input bit [1:0] code);
        exp_t e;
        e.is_err = 1; e.b = 0; e.code = code; e.cnt = m_count;
        q.push_back(e);
        m_synced = 0;
    endtask

    task automatic push_bit(input bit b);
        exp_t e;
        if (m_count < 65535) m_count++;
        e.is_err = 0; e.b = b; e.code = 0; e.cnt = m_count;
        q.push_back(e);
    endtask

    task automatic classify(input int hi);
        if (hi >= T1H_MIN && hi <= T1H_MAX)      push_bit(1'b1);
        else if (hi >= T0H_MIN && hi <= T0H_MAX) push_bit(1'b0);
        else if (hi > T1H_MAX + 1)               push_err(2'd1);
        else                                     push_err(2'd0);
    endtask

    task automatic drive(input bit level, input int n);
        din = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic low_phase(input int lo);
        if (lo > TRESET) begin
            m_synced = 1;
            m_armed  = 1;
        end
        drive(1'b0, lo);
        if (lo >= TLOW_MIN) begin
            check("treset_after_low", o_treset, m_armed);
            check("bit_cnt_after_low", o_bit_cnt, m_count);
        end
    endtask

    task automatic high_phase(input int lo, input int hi);
        if (m_synced) begin
            if (m_armed) begin
                m_armed = 0;
                m_count = 0;
                classify(hi);
            end else if (lo < TLOW_MIN) begin
                push_err(2'd2);
            end else begin
                classify(hi);
            end
        end
        drive(1'b1, hi);
        if (hi >= 5) check("treset_during_high", o_treset, 0);
    endtask

    task automatic pulse(input int lo, input int hi);
        low_phase(lo);
        high_phase(lo, hi);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int widths[7];
        widths = '{9, 10, 27, 28, 29, 30, 50};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_bit", o_bit, 0);
        check("reset_valid", o_bit_valid, 0);
        check("reset_err", o_err, 0);
        check("reset_code", o_err_code, 0);
        check("reset_treset", o_treset, 0);
        check("reset_bit_cnt", o_bit_cnt, 0);

        // 1: first treset after release
        rst_n = 1'b1;
        n = 0;
        while (!o_treset && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("treset_latency_in_range", longint'(n >= 2500 && n <= 2506), 1);
        m_synced = 1;
        m_armed  = 1;

        // 2: 24-bit frame alternating 1/0
        for (int i = 0; i < 24; i++) begin
            if (i == 0)          pulse(100, 40);
            else if (i % 2 == 1) pulse(45, 20);
            else                 pulse(65, 40);
        end
        low_phase(3000);
        check("frame_bit_cnt", o_bit_cnt, 24);
        check("frame_treset", o_treset, 1);

        // 3: window edges
        foreach (widths[i]) pulse(LONG_LO, widths[i]);
        pulse(60, 10);
        pulse(60, 27);
        pulse(60, 30);
        pulse(60, 50);

        // 4: stuck high
        pulse(LONG_LO, 200);

        // 5: legal bit then a short low
        pulse(LONG_LO, 40);
        pulse(5, 40);
        low_phase(LONG_LO);
        check("cnt_after_low_short", o_bit_cnt, 1);

        // Randomised pulse trains
        for (int k = 0; k < 30; k++) begin
            int r, lo, hi;
            r = $urandom_range(0, 99);
            if ((!m_synced && r < 90) || r < 4) lo = TRESET + 20 + $urandom_range(0, 100);
            else if (r < 12)                    lo = $urandom_range(3, 9);
            else                                lo = $urandom_range(10, 300);
            r = $urandom_range(0, 99);
            if (r < 40)      hi = $urandom_range(T0H_MIN, T0H_MAX);
            else if (r < 80) hi = $urandom_range(T1H_MIN, T1H_MAX);
            else             hi = $urandom_range(3, 80);
            pulse(lo, hi);
        end

        // 6: asynchronous reset in the middle of a high pulse
        pulse(LONG_LO, 40);
        low_phase(60);
        din = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_bit", o_bit, 0);
        check("midreset_valid", o_bit_valid, 0);
        check("midreset_err", o_err, 0);
        check("midreset_code", o_err_code, 0);
        check("midreset_treset", o_treset, 0);
        check("midreset_bit_cnt", o_bit_cnt, 0);
        m_synced = 0;
        m_armed  = 0;
        m_count  = 0;
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 10);
        pulse(50, 20);
        pulse(80, 40);
        pulse(200, 30);
        pulse(LONG_LO, 40);
        pulse(60, 20);

        low_phase(LONG_LO);
        repeat (10) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
